// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: M-extension
// func3 codes and the 2-bit FSM state encoding.
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit. One bit per cycle:
// shift-add multiply and restoring divide share the hi/lo shift register
// and a single WIDTH+1-bit adder. Operands are reduced to magnitudes on
// acceptance and the sign is restored in the FIX cycle.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               neg_q;     // product / quotient must be negated
  logic               neg_r;     // remainder takes the dividend's sign
  logic               dz;        // divide by zero: bypass sign correction
  logic [WIDTH-1:0]   hi;        // product high half / partial remainder
  logic [WIDTH-1:0]   lo;        // multiplier bits / dividend -> quotient
  logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude

  // acceptance-time decode
  logic [1:0]         sgn;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // shared adder
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic               div_ge;

  // FIX-cycle result selection
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_result;

  // {op_a signed, op_b signed} for each func3
  function automatic logic [1:0] op_signs(input logic [2:0] f);
    case (f)
      F_MULH, F_DIV, F_REM:           return 2'b11;
      F_MULHSU:                       return 2'b10;
      F_MUL, F_MULHU, F_DIVU, F_REMU: return 2'b00;
      default:                        return 2'b00;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if2(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  // Sign/magnitude conversion of the incoming operands
  always_comb begin
    sgn   = op_signs(func3);
    sa    = sgn[1] & op_a[WIDTH-1];
    sb    = sgn[0] & op_b[WIDTH-1];
    a_mag = neg_if(sa, op_a);
    b_mag = neg_if(sb, op_b);
  end

  // Single adder: add multiplicand (multiply) or subtract divisor (divide)
  always_comb begin
    add_a   = {1'b0, hi};
    add_b   = '0;
    add_cin = 1'b0;
    if (op_q[2]) begin
      add_a   = {hi, lo[WIDTH-1]};
      add_b   = ~{1'b0, mcand};
      add_cin = 1'b1;
    end else if (lo[0]) begin
      add_b   = {1'b0, mcand};
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    // carry out of the subtract means the shifted remainder >= divisor
    div_ge  = add_sum[WIDTH+1];
  end

  // Sign correction and result select for the FIX cycle
  always_comb begin
    prod_fix = neg_if2(neg_q, {hi, lo});
    quo_fix  = neg_if(neg_q, lo);
    rem_fix  = neg_if(neg_r, hi);
    if (!op_q[2]) begin
      fix_result = (op_q == F_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else if (dz) begin
      fix_result = op_q[1] ? hi : lo;
    end else begin
      fix_result = op_q[1] ? rem_fix : quo_fix;
    end
  end

  // Control FSM, iteration counter and shared datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= func3;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            cnt   <= '0;
            busy  <= 1'b1;
            if (func3[2] && (op_b == '0)) begin
              // divide by zero: preload the architectural results directly
              dz    <= 1'b1;
              hi    <= op_a;
              lo    <= '1;
              mcand <= '0;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              hi    <= '0;
              mcand <= func3[2] ? b_mag : a_mag;
              lo    <= func3[2] ? a_mag : b_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            hi <= div_ge ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end else begin
            {hi, lo} <= {add_sum[WIDTH:0], lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= fix_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed and random operations checked
// against an arithmetic reference model, plus start/flush/reset behaviour.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   func3;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int total;
  int bad;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, scramble the inputs afterwards, check latency and result
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int exp_lat;
    exp_lat = (f[2] && b == 0) ? 2 : W + 2;
    func3 = f;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    func3 = 3'($urandom);
    op_a  = $urandom;
    op_b  = $urandom;
    lat   = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp);
    tick();
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] exp0;
    logic [31:0] prev;
    int          ndone;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    func3 = 3'd0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    // directed arithmetic cases
    do_op("mul_7x-3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div_-7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    do_op("rem_-7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    do_op("divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14);
    do_op("remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2);
    do_op("div_5_0",      3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF);
    do_op("remu_5_0",     3'd7, 32'd5,          32'd0,         32'd5);
    do_op("rem_-5_0",     3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);
    do_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

    // random operations, with some zero divisors and overflow pairs mixed in
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, model(rf, ra, rb));
    end

    // start pulses while busy are ignored: exactly one done, original result
    exp0  = model(3'd4, 32'hFFFF_FC18, 32'd37);
    func3 = 3'd4;
    op_a  = 32'hFFFF_FC18;
    op_b  = 32'd37;
    start = 1'b1;
    tick();
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      start = 1'b1;
      func3 = 3'($urandom);
      op_a  = $urandom;
      op_b  = $urandom;
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_res",   result, exp0);
    prev = exp0;

    // flush in cycle 10 aborts: busy drops next cycle, no done, result kept
    func3 = 3'd0;
    op_a  = 32'd123;
    op_b  = 32'd456;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) chk("calc_busy", {31'd0, busy}, 32'd1);
      if (done) ndone++;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    for (int c = 0; c < 50; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("flush_ndone", 32'(ndone), 32'd0);
    chk("flush_res",   result, prev);

    // flush beats a simultaneous start
    func3 = 3'd0;
    op_a  = 32'd9;
    op_b  = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("flush_vs_start_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of CALC, then a normal op
    func3 = 3'd1;
    op_a  = $urandom;
    op_b  = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    chk("midrst_done",   {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    do_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port func3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op_a  input  WIDTH  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port op_b  input  WIDTH  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port flush  input  1  abort any operation in flight.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; drives the pipeline stall.
REQ-010 SHALL have port done  output  1  single-cycle pulse; result is valid.
REQ-011 SHALL have port result  output  WIDTH  operation result; holds its value until the next done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 IDLE with start=1 and flush=0 SHALL latch func3 and both operands and go to CALC.
- Signed operands SHALL first be converted to magnitudes, with the result sign recorded.
- Signedness per op: MULH both signed; MULHSU op_a signed only; DIV/REM signed.
REQ-014 CALC SHALL run exactly WIDTH cycles at one bit per cycle, under a counter that counts 0..WIDTH-1.
- Multiply: shift-add into a 2*WIDTH-bit product.
- Divide: restoring divide producing quotient and remainder.
REQ-015 FIX SHALL last 1 cycle, apply sign correction and select the result:
- MUL: low half of the product; MULH/MULHSU/MULHU: high half.
- DIV/DIVU: quotient; REM/REMU: remainder.
- Quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
REQ-016 DONE SHALL assert done=1 for one cycle with result updated, then return to IDLE.
REQ-017 Latency SHALL be fixed: done is high exactly WIDTH+2 cycles after the cycle in which start was accepted (34 for WIDTH=32).
REQ-018 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-019 start while busy=1 SHALL be ignored; no queuing.
REQ-020 start in the DONE cycle SHALL be ignored; a new start is accepted from the next IDLE cycle.
REQ-021 Divide by zero (op_b=0) SHALL skip CALC and go IDLE->FIX->DONE, with done 2 cycles after start.
- DIV/DIVU result = all ones; REM/REMU result = op_a.
REQ-022 Signed overflow (DIV/REM with op_a = most-negative and op_b = -1) SHALL produce DIV result = op_a and REM result = 0.
- Either latency is allowed, but it SHALL be fixed per implementation.
REQ-023 flush=1 in any state SHALL force IDLE next cycle with no done pulse; result is unchanged.
- flush takes priority over simultaneous start.
REQ-024 Operands and func3 changing after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-025 rst=1 SHALL force IDLE, busy=0, done=0, result=0, and clear the counter and datapath registers on the next clk edge.
REQ-026 Reset SHALL dominate flush and start; reset mid-CALC SHALL abort with no done pulse.

Structure
REQ-027 Shared package muldiv_pkg SHALL hold the func3 encodings and the FSM state encoding (2-bit).
REQ-028 No sub-module; the FSM, counter, shared shift register and adder/subtractor SHALL be in one module, with a single WIDTH+1-bit adder serving both multiply and divide.

Verification (WIDTH=32)
REQ-029 MUL 7 x -3 -> done at cycle 34, result=0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 DIV 5/0 -> 0xFFFFFFFF after 2 cycles; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-033 start pulses in cycles 1..10 during an op -> exactly one done; flush at cycle 10 -> no done, busy=0 next cycle.
REQ-034 rst asserted mid-CALC -> next cycle busy=0, done=0, result=0; then MUL 3x4 -> 12 at the normal latency.
